// File: rtl/feedback_seq_gen_pkg.sv
// feedback_seq_pkg: shared types and helpers for feedback_seq_gen.
//   mode_e      - feedback network selector (LFSR / Johnson / ring / hold)
//   TAPS_W*     - maximal-length XNOR tap masks for common widths
//   next_state  - width-agnostic next-state function, operands are
//                 zero-extended to MAX_W bits by the caller
package feedback_seq_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_LFSR    = 2'd0,
        MODE_JOHNSON = 2'd1,
        MODE_RING    = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam logic [3:0]  TAPS_W4  = 4'b1100;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    // Shift left by one inside a w-bit window, inserting the mode's feedback
    // bit at position 0. Bits at and above w stay zero.
    function automatic logic [MAX_W-1:0] next_state(input mode_e m,
                                                    input logic [MAX_W-1:0] s,
                                                    input logic [MAX_W-1:0] taps,
                                                    input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic             fb;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        case (m)
            MODE_LFSR:    fb = ~^(s & taps);
            MODE_JOHNSON: fb = ~s[w-1];
            MODE_RING:    fb = s[w-1];
            default:      fb = 1'b0;
        endcase
        if (m == MODE_HOLD)
            return s;
        return ((s << 1) | {{(MAX_W-1){1'b0}}, fb}) & mask;
    endfunction

endpackage

// File: rtl/feedback_seq_gen_if.sv
// feedback_seq_gen_if: load handshake into the sequence generator.
//   load_valid - producer has a value to load
//   load_ready - generator can accept a load this cycle
//   load_data  - value written to both state and period reference
interface feedback_seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;

    modport master (output load_valid, output load_data, input  load_ready);
    modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/feedback_seq_gen_meter.sv
// seq_period_meter: measures the number of advances it takes the state to
// return to a reference value.
//   restart_i/restart_ref_i - load a new reference and clear the count
//   adv_i/next_i            - state is advancing to next_i this cycle
//   period_o                - last measured period (held between pulses)
//   period_valid_o          - one-cycle pulse after a match
module seq_period_meter #(
    parameter int               WIDTH = 4,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart_i,
    input  logic [WIDTH-1:0] restart_ref_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] next_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] ref_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_q          <= SEED;
            cnt_q          <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            if (restart_i) begin
                ref_q <= restart_ref_i;
                cnt_q <= '0;
            end else if (adv_i) begin
                if (next_i == ref_q) begin
                    // A saturated count would wrap to 0 on +1; clamp instead.
                    period_o       <= (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                    period_valid_o <= 1'b1;
                    cnt_q          <= '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/feedback_seq_gen.sv
// feedback_seq_gen: registered pattern/sequence source.
//   clk, reset (sync, active low)
//   en           - advance enable
//   mode         - 0 LFSR, 1 Johnson, 2 ring, 3 hold
//   lif          - load handshake (slave side)
//   state_q, y   - current state and its MSB as serial output
//   period       - last measured return-to-reference period
//   period_valid - one-cycle pulse per measured period
//   lockup       - one-cycle pulse when LFSR all-ones state is recovered
// Per-cycle priority: load > mode change > lockup recovery > advance.
module feedback_seq_gen
    import feedback_seq_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W4,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    feedback_seq_gen_if.slave     lif,
    output logic [WIDTH-1:0]      state_q,
    output logic                  y,
    output logic [CNT_W-1:0]      period,
    output logic                  period_valid,
    output logic                  lockup
);
    mode_e            mode_in, mode_q, mode_d;
    logic             load_ready_q;
    logic [WIDTH-1:0] state_d, nxt;
    logic             restart, adv_m, lock_d;
    logic [WIDTH-1:0] restart_ref;

    assign mode_in        = mode_e'(mode);
    assign lif.load_ready = load_ready_q;
    assign y              = state_q[WIDTH-1];

    // Feedback uses the registered mode: a new mode first takes a
    // no-advance cycle that only latches it.
    assign nxt = WIDTH'(next_state(mode_q, MAX_W'(state_q), MAX_W'(TAPS), WIDTH));

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        restart     = 1'b0;
        restart_ref = state_q;
        adv_m       = 1'b0;
        lock_d      = 1'b0;
        if (lif.load_valid && load_ready_q) begin
            state_d     = lif.load_data;
            restart     = 1'b1;
            restart_ref = lif.load_data;
        end else if (mode_in != mode_q) begin
            mode_d  = mode_in;
            restart = 1'b1;
        end else if (mode_in == MODE_LFSR && en && (&state_q)) begin
            // All-ones is the XNOR LFSR's stuck state.
            state_d     = SEED;
            restart     = 1'b1;
            restart_ref = SEED;
            lock_d      = 1'b1;
        end else if (en && mode_in != MODE_HOLD) begin
            state_d = nxt;
            adv_m   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SEED;
            mode_q       <= MODE_LFSR;
            load_ready_q <= 1'b0;
            lockup       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            load_ready_q <= 1'b1;
            lockup       <= lock_d;
        end
    end

    seq_period_meter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SEED  (SEED)
    ) u_meter (
        .clk            (clk),
        .reset          (reset),
        .restart_i      (restart),
        .restart_ref_i  (restart_ref),
        .adv_i          (adv_m),
        .next_i         (nxt),
        .period_o       (period),
        .period_valid_o (period_valid)
    );
endmodule

// File: tb/tb_feedback_seq_gen.sv
module tb_feedback_seq_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  state_q;
    logic        y;
    logic [15:0] period;
    logic        period_valid;
    logic        lockup;

    int n_vec = 0;
    int n_err = 0;

    feedback_seq_gen_if #(.WIDTH(4)) lif ();

    feedback_seq_gen #(
        .WIDTH (4),
        .TAPS  (4'b1100),
        .SEED  (4'b0000),
        .CNT_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .lif          (lif.slave),
        .state_q      (state_q),
        .y            (y),
        .period       (period),
        .period_valid (period_valid),
        .lockup       (lockup)
    );

    always #5 clk = ~clk;

    // Hand-derived XNOR LFSR (taps 3,2) sequence starting from 0000.
    logic [3:0] lfsr_seq [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                                  4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    logic [3:0] john_seq [8]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] ring_seq [4]  = '{4'h2, 4'h4, 4'h8, 4'h1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; mode = 2'd0;
        lif.load_valid = 1'b1; lif.load_data = 4'h9;
        step(); step();
        chk("rst_state", state_q, 4'h0);
        chk("rst_ready", lif.load_ready, 1'b0);
        chk("rst_period", period, 16'd0);
        chk("rst_pv", period_valid, 1'b0);
        chk("rst_lockup", lockup, 1'b0);

        reset = 1'b1; en = 1'b0; lif.load_valid = 1'b0;
        step();
        chk("rel_ready", lif.load_ready, 1'b1);
        chk("rel_state", state_q, 4'h0);

        // Full LFSR cycle
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("lfsr_s%0d", i), state_q, lfsr_seq[i]);
            chk($sformatf("lfsr_pv%0d", i), period_valid, (i == 14));
        end
        chk("lfsr_period", period, 16'd15);
        step();
        chk("lfsr_wrap", state_q, 4'h1);
        chk("lfsr_pv_clr", period_valid, 1'b0);
        chk("lfsr_period_hold", period, 16'd15);

        // Enable freeze for 5 cycles
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("frz_s%0d", i), state_q, 4'h1);
        end
        en = 1'b1;
        for (int i = 1; i < 15; i++) begin
            step();
            chk($sformatf("frz_lfsr_s%0d", i), state_q, lfsr_seq[i]);
            chk($sformatf("frz_pv%0d", i), period_valid, (i == 14));
        end
        chk("frz_period", period, 16'd15);

        // Johnson from 0000
        mode = 2'd1;
        step();
        chk("john_chg_state", state_q, 4'h0);
        chk("john_chg_pv", period_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("john_s%0d", i), state_q, john_seq[i]);
            chk($sformatf("john_pv%0d", i), period_valid, (i == 7));
            chk($sformatf("john_lk%0d", i), lockup, 1'b0);
        end
        chk("john_period", period, 16'd8);

        // Ring: mode change, then all-zeros rotates onto itself (period 1)
        mode = 2'd2;
        step();
        chk("ring_chg_state", state_q, 4'h0);
        step();
        chk("ring0_state", state_q, 4'h0);
        chk("ring0_pv", period_valid, 1'b1);
        chk("ring0_period", period, 16'd1);

        // Load 0001 with en=1: load wins, no advance
        lif.load_valid = 1'b1; lif.load_data = 4'h1;
        step();
        chk("ld_state", state_q, 4'h1);
        chk("ld_pv", period_valid, 1'b0);
        lif.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ring_s%0d", i), state_q, ring_seq[i]);
            chk($sformatf("ring_y%0d", i), y, (ring_seq[i] == 4'h8));
            chk($sformatf("ring_pv%0d", i), period_valid, (i == 3));
        end
        chk("ring_period", period, 16'd4);

        // Lockup recovery
        mode = 2'd0;
        step();
        chk("lk_chg_state", state_q, 4'h1);
        lif.load_valid = 1'b1; lif.load_data = 4'hF;
        step();
        chk("lk_ld_state", state_q, 4'hF);
        chk("lk_ld_lockup", lockup, 1'b0);
        lif.load_valid = 1'b0;
        step();
        chk("lk_state", state_q, 4'h0);
        chk("lk_pulse", lockup, 1'b1);
        step();
        chk("lk_after_state", state_q, 4'h1);
        chk("lk_after_pulse", lockup, 1'b0);
        for (int i = 1; i < 15; i++) begin
            step();
            chk($sformatf("lk_lfsr_s%0d", i), state_q, lfsr_seq[i]);
        end
        chk("lk_pv", period_valid, 1'b1);
        chk("lk_period", period, 16'd15);

        // Reset mid-operation with a concurrent load
        reset = 1'b0; lif.load_valid = 1'b1; lif.load_data = 4'h5; en = 1'b1;
        step();
        chk("mrst_state", state_q, 4'h0);
        chk("mrst_ready", lif.load_ready, 1'b0);
        chk("mrst_pv", period_valid, 1'b0);
        chk("mrst_lockup", lockup, 1'b0);
        chk("mrst_period", period, 16'd0);
        reset = 1'b1; lif.load_valid = 1'b0; en = 1'b0;
        step();
        chk("mrst_rel_ready", lif.load_ready, 1'b1);
        chk("mrst_rel_state", state_q, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/feedback_seq_gen.md
Name: feedback_seq_gen

Overview:
Parametrised, registered successor to the team's gate-level feedback loop block. It holds a WIDTH-bit state register whose next state comes from a selectable feedback network: XNOR-Fibonacci LFSR, Johnson counter, ring rotate, or hold. It adds a load handshake, lockup recovery and on-line period measurement. It sits in the test/stimulus area as a deterministic pattern and sequence source.

Parameters:
WIDTH, 4, state register width (>=3)
TAPS, 4'b1100, LFSR tap mask, bit i set = state[i] feeds the XNOR reduction (width WIDTH)
SEED, '0, reset and lockup-recovery state (must not be all-ones)
CNT_W, 16, period counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
en  input  1  advance enable
mode  input  2  0=LFSR, 1=Johnson, 2=ring, 3=hold
load_valid  input  1  load request
load_ready  output  1  load can be accepted
load_data  input  WIDTH  value to load
state_q  output  WIDTH  current state
y  output  1  serial output, equal to state_q[WIDTH-1]
period  output  CNT_W  last measured period
period_valid  output  1  one-cycle pulse when state returns to reference
lockup  output  1  one-cycle pulse on LFSR lockup recovery

Behaviour:
- Reset (reset==0 at a clk edge):
  - state_q=SEED, ref=SEED, cnt=0, mode_q=0, period=0.
  - period_valid=0, lockup=0, load_ready=0.
- After reset is released, load_ready=1 every cycle.
- Next-state functions; "adv" means the state register takes the next value:
  - LFSR: {state[W-2:0], ~^(state & TAPS)}
  - Johnson: {state[W-2:0], ~state[W-1]}
  - ring: {state[W-2:0], state[W-1]}
  - hold: no advance
- Priority per cycle, highest first:
  1. Load: load_valid && load_ready. state_q<=load_data, ref<=load_data, cnt<=0. No advance, even if en=1.
  2. Mode change: mode != mode_q. mode_q<=mode, ref<=state_q, cnt<=0. No advance this cycle.
  3. Lockup: mode==LFSR && en && state_q all-ones. state_q<=SEED, ref<=SEED, cnt<=0, lockup=1 next cycle.
  4. Advance: en && mode!=hold. state_q<=next. If next==ref: period<=cnt+1, period_valid=1 next cycle, cnt<=0. Otherwise cnt<=cnt+1, saturating at 2^CNT_W-1.
  5. Otherwise: everything holds. en=0 or hold mode freezes cnt.
- Output timing:
  - All outputs are registered.
  - period_valid and lockup are 1 for exactly one cycle and 0 otherwise.
  - period keeps its last value between pulses.
- Saturation: when cnt saturates, no period_valid fires until a match occurs. When it does, period reports the saturated value plus 1 wrapped — implementers clamp it to 2^CNT_W-1 instead.
- All-ones loads: a load of all-ones in LFSR mode is accepted. The next enabled LFSR cycle triggers recovery. Ring with all-zeros or all-ones gives period=1 on every advance (legal).
- Reset mid-operation overrides everything, including a load in the same cycle.

Decomposition:
- Package feedback_seq_pkg:
  - mode enum (MODE_LFSR, MODE_JOHNSON, MODE_RING, MODE_HOLD)
  - function next_state(mode, state, taps)
  - default TAPS constants for WIDTH 4/8/16 (4'b1100, 8'hB8, 16'hB400)
- One natural sub-module: seq_period_meter, holding ref, cnt, period and period_valid with restart/advance/match inputs. The top holds state, mode_q and the priority logic.

Test Plan:
- Reset, then en=1, mode=0, WIDTH=4, TAPS=1100, SEED=0 -> states 0001, 0011, 0111, 1110, …, 15 distinct values; period_valid with period=15 when state_q returns to 0000.
- mode=1 from 0000 -> one mode-change cycle with no advance, then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; period=8.
- load 0001 in mode=2 with en=1 the same cycle -> state_q=0001 and no advance; then 0010, 0100, 1000, 0001; period=4, y=1 only when state_q=1000.
- Load 1111 in mode=0, en=1 -> next cycle state_q=0000 (SEED) and lockup pulse; period measurement restarts from 0000.
- en toggled 0 for 5 cycles mid-sequence in mode=0 -> state and cnt frozen; measured period is still 15.
- reset low while load_valid=1 and en=1 -> state_q=SEED, load_ready=0, no pulses; load_ready=1 the cycle after release.
